// File: rtl/vga_timing_gen_640x480_if.sv
// Raster timing bus: advance enable toward the generator, counts/syncs/markers back out.
// Widths are set by the instantiating context to match the generator's totals.
interface vga_timing_gen_640x480_if #(
    parameter int HW      = 10,
    parameter int VW      = 10,
    parameter int FRAME_W = 16
);
    logic               clk_en;
    logic [HW-1:0]      hcount;
    logic [VW-1:0]      vcount;
    logic               hsync;
    logic               vsync;
    logic               active;
    logic               line_start;
    logic               new_frame;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  clk_en,
        output hcount, vcount, hsync, vsync, active, line_start, new_frame, frame_count
    );

    modport slave (
        output clk_en,
        input  hcount, vcount, hsync, vsync, active, line_start, new_frame, frame_count
    );
endinterface

// File: rtl/vga_timing_gen_640x480.sv
// Raster timing generator: pixel/line counters, syncs, active flag, line/frame pulses, frame counter.
// Decode is registered from next-state counts (zero latency vs counts); clk_en low freezes every register.
module vga_timing_gen_640x480 #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int FRAME_W  = 16
) (
    input  logic                              clk_25mhz,
    input  logic                              rst,
    vga_timing_gen_640x480_if.master          vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          SYNC_OFF  = ~SYNC_POL;

    logic [HW-1:0]      h_q, h_nxt;
    logic [VW-1:0]      v_q, v_nxt;
    logic [FRAME_W-1:0] frame_q;
    logic               frame_wrap;
    logic               active_q, hsync_q, vsync_q, line_start_q, new_frame_q;

    // Totals are not powers of two, so wrap on explicit compare rather than overflow.
    always_comb begin
        h_nxt      = h_q + 1'b1;
        v_nxt      = v_q;
        frame_wrap = 1'b0;
        if (h_q == H_LAST) begin
            h_nxt = '0;
            if (v_q == V_LAST) begin
                v_nxt      = '0;
                frame_wrap = 1'b1;
            end else begin
                v_nxt = v_q + 1'b1;
            end
        end
    end

    // Reset parks on the last pixel so the first enabled edge lands on (0,0).
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            h_q          <= H_LAST;
            v_q          <= V_LAST;
            frame_q      <= '0;
            active_q     <= 1'b0;
            hsync_q      <= SYNC_OFF;
            vsync_q      <= SYNC_OFF;
            line_start_q <= 1'b0;
            new_frame_q  <= 1'b0;
        end else if (vid.clk_en) begin
            h_q          <= h_nxt;
            v_q          <= v_nxt;
            if (frame_wrap) begin
                frame_q <= frame_q + 1'b1;
            end
            active_q     <= (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
            hsync_q      <= ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? SYNC_POL : SYNC_OFF;
            vsync_q      <= ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? SYNC_POL : SYNC_OFF;
            line_start_q <= (h_nxt == '0);
            new_frame_q  <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    assign vid.hcount      = h_q;
    assign vid.vcount      = v_q;
    assign vid.frame_count = frame_q;
    assign vid.active      = active_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.line_start  = line_start_q;
    assign vid.new_frame   = new_frame_q;
endmodule
